// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: controller state encoding and register-index width shared by the pipeline_ctrl files.
package pipeline_ctrl_pkg;
    localparam int REG_IDX_W = 5;
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the datapath and stage enables/flushes back to it.
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;
    logic [REG_IDX_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_fault;
    modport master (
        output id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_fault
    );
    modport slave (
        input  id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_fault
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detector between the ID instruction and a load in EX.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_uses_rs1,
    input  logic                 i_uses_rs2,
    input  logic                 i_ex_mem_read,
    output logic                 o_load_use
);
    // x0 never carries a real dependency
    assign o_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                        ((i_uses_rs1 && i_rs1 == i_ex_rd) || (i_uses_rs2 && i_rs2 == i_ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller with memory-wait timeout; PIPE_PERF_CNT_EN adds
// stall_cycles/flush_count performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipeline_ctrl: MEM_TIMEOUT and CNT_W must be positive");
    end

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_fault;
    logic              w_load_use, w_mem_stall, w_freeze, w_branch, w_lu_stall;

    hazard_detect u_hazard (
        .i_rs1        (bus.id_rs1),
        .i_rs2        (bus.id_rs2),
        .i_ex_rd      (bus.ex_rd),
        .i_uses_rs1   (bus.id_uses_rs1),
        .i_uses_rs2   (bus.id_uses_rs2),
        .i_ex_mem_read(bus.ex_mem_read),
        .o_load_use   (w_load_use)
    );

    // once waiting, only mem_ready can release the pipeline
    assign w_mem_stall = !bus.mem_ready && (r_state == MEM_WAIT || bus.mem_req);
    assign w_freeze    = rst || r_state == HALT || w_mem_stall;
    assign w_branch    = !w_freeze && bus.ex_branch_taken;
    assign w_lu_stall  = !w_freeze && !w_branch && w_load_use;

    always_comb begin
        bus.pc_en      = !w_freeze && !w_lu_stall;
        bus.ifid_en    = !w_freeze && !w_lu_stall;
        bus.idex_en    = !w_freeze;
        bus.exmem_en   = !w_freeze;
        bus.memwb_en   = !w_freeze;
        bus.ifid_flush = w_branch;
        bus.idex_flush = w_branch || w_lu_stall;
        bus.mem_fault  = r_fault;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                RUN: if (w_mem_stall) begin
                    r_state <= MEM_WAIT;
                    r_wait  <= WAIT_W'(1);
                end
                MEM_WAIT: if (bus.mem_ready) r_state <= RUN;
                else begin
                    r_wait <= r_wait + 1'b1;
                    if (int'(r_wait) + 1 >= MEM_TIMEOUT) begin
                        r_state <= HALT;
                        r_fault <= 1'b1;
                    end
                end
                default: r_fault <= 1'b1;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!bus.pc_en) stall_cycles <= stall_cycles + 1'b1;
            if (w_branch) flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of pipeline_ctrl outputs (MEM_TIMEOUT=4); counter checks under PIPE_PERF_CNT_EN.
module tb_pipeline_ctrl;
    localparam logic [7:0] NORM = 8'b1111_1000;
    localparam logic [7:0] LU   = 8'b0011_1010;
    localparam logic [7:0] BR   = 8'b1111_1110;
    localparam logic [7:0] FRZ  = 8'b0000_0000;
    localparam logic [7:0] HLT  = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    pipeline_ctrl_if bus ();
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    wire [7:0] outs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                       bus.ifid_flush, bus.idex_flush, bus.mem_fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rd = '0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0; bus.ex_mem_read = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        bus.ex_mem_read = 1'b1; bus.ex_rd = rd; bus.id_rs1 = rd; bus.id_uses_rs1 = 1'b1;
    endtask

    initial begin
        idle();
        cyc("reset_outs", FRZ);
        rst = 1'b0;
`ifdef PIPE_PERF_CNT_EN
        @(negedge clk);
        check("cnt_reset_stall", stall_cycles, 0);
        check("cnt_reset_flush", flush_count, 0);
`endif
        cyc("idle", NORM);
        load_use(5'd5);
        cyc("load_use_rs1", LU);
        idle();
        cyc("after_bubble", NORM);
        load_use(5'd0);
        cyc("rd_zero_no_stall", NORM);
        idle();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mem_wait", FRZ);
        bus.mem_ready = 1'b1;
        cyc("mem_ready", NORM);
        idle();
        cyc("back_to_run", NORM);
`ifdef PIPE_PERF_CNT_EN
        @(negedge clk);
        check("cnt_stall4", stall_cycles, 4);
`endif
        bus.ex_branch_taken = 1'b1;
        cyc("branch", BR);
        idle();
`ifdef PIPE_PERF_CNT_EN
        @(negedge clk);
        check("cnt_flush1", flush_count, 1);
`endif
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
        cyc("load_use_rs2", LU);
        bus.id_uses_rs2 = 1'b0;
        cyc("rs2_unused", NORM);
        idle();
        bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        cyc("zero_wait_mem", NORM);
        idle();
        load_use(5'd9);
        bus.ex_branch_taken = 1'b1;
        cyc("branch_beats_lu", BR);
        idle();
        bus.mem_req = 1'b1;
        load_use(5'd3);
        cyc("mem_beats_lu", FRZ);
        bus.mem_req = 1'b0;
        cyc("wait_ignores_req", FRZ);
        bus.mem_ready = 1'b1;
        cyc("wait_release_lu", LU);
        idle();
        bus.mem_req = 1'b1;
        cyc("wait_enter", FRZ);
        bus.mem_ready = 1'b1; bus.ex_branch_taken = 1'b1;
        cyc("wait_release_br", BR);
        idle();
        cyc("run_after_br", NORM);
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc("timeout_wait", FRZ);
        cyc("halt", HLT);
        bus.mem_ready = 1'b1; bus.ex_branch_taken = 1'b1;
        cyc("halt_sticky", HLT);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_enables", {25'd0, outs[7:1]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("run_after_rst", NORM);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max consecutive MEM_WAIT cycles before fault.
REQ-002 SHALL have parameter CNT_W, default 32: width of performance counters.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock, sole clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-007 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-008 ex_rd  in  5  destination of the instruction in EX.
REQ-009 ex_mem_read  in  1  EX instruction is a load.
REQ-010 ex_branch_taken  in  1  EX resolved a taken branch/jump.
REQ-011 mem_req  in  1  MEM stage has a data-memory access outstanding.
REQ-012 mem_ready  in  1  data memory completes the access this cycle.
REQ-013 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables.
REQ-014 ifid_flush, idex_flush  out  1 each  load a bubble (all-zero controls) into IF/ID, ID/EX.
REQ-015 mem_fault  out  1  sticky: memory access timed out.

Function
REQ-016 States SHALL be RUN, MEM_WAIT, HALT; outputs decoded combinationally from state and inputs.
REQ-017 Priority in RUN SHALL be: memory stall > branch flush > load-use stall > normal.
REQ-018 RUN, mem_req=1 and mem_ready=0: all enables 0, flushes 0; next state MEM_WAIT, wait counter cleared to 1.
REQ-019 RUN, mem_req=1 and mem_ready=1: treated as normal (zero-wait access).
REQ-020 RUN, ex_branch_taken=1 (no memory stall): all enables 1, ifid_flush=1, idex_flush=1; stay RUN.
REQ-021 Load-use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-022 RUN, load-use, no branch/memory stall: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1; exactly one bubble.
REQ-023 RUN, no event: all enables 1, flushes 0.
REQ-024 MEM_WAIT, mem_ready=0: all enables 0, counter increments; when counter reaches MEM_TIMEOUT, next state HALT and mem_fault set.
REQ-025 MEM_WAIT, mem_ready=1: outputs evaluated as in RUN (branch/load-use rules apply, memory stall ignored); next state RUN.
REQ-026 HALT: all enables 0, flushes 0, mem_fault=1, until rst.
REQ-027 Freezing MEM/WB SHALL be safe: repeated write-back of held rd/data is idempotent.

Reset
REQ-028 While rst=1: all enables 0, all flushes 0; at the clock edge state goes to RUN, wait counter 0, mem_fault 0, counters 0.
REQ-029 rst during MEM_WAIT or HALT SHALL abandon the wait; first cycle after rst low is RUN.

Configuration
REQ-030 Macro PIPE_PERF_CNT_EN defined: outputs stall_cycles[CNT_W] (cycles with pc_en=0, rst=0) and flush_count[CNT_W] (cycles with idex_flush=1 due to branch), both wrapping modulo 2^CNT_W.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package SHALL hold the state enum (RUN, MEM_WAIT, HALT) and the 5-bit register-index width constant.
REQ-033 Load-use comparator SHALL be sub-module hazard_detect (combinational); FSM and counters stay in pipeline_ctrl.

Verification
REQ-034 ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle: pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
REQ-035 Same with ex_rd=0 -> no stall, all enables 1.
REQ-036 mem_req=1, mem_ready low 3 cycles then high -> enables 0 for 3 cycles, 1 in the 4th; state back to RUN.
REQ-037 MEM_TIMEOUT=4, mem_ready held 0 -> mem_fault=1 after 4 wait cycles, enables stay 0; rst pulse -> mem_fault=0, RUN.
REQ-038 ex_branch_taken=1 together with load-use -> ifid_flush=1, idex_flush=1, pc_en=1 (branch wins).
REQ-039 With PIPE_PERF_CNT_EN, scenarios 034+036 -> stall_cycles=4; one branch -> flush_count=1.
